countdown_timer: RTL and testbench



---
 rtl/countdown_timer.sv | 101 ++++++++++
 tb/tb_countdown_timer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// One-shot countdown timer with prescaler and a sticky Done flag; spaces SDRAM commands.
// Optional periodic auto-reload mode is enabled by defining COUNTDOWN_AUTORELOAD_EN.
module countdown_timer #(
   parameter int unsigned COUNT    = 1,
   parameter int unsigned PRESCALE = 1,
   localparam int unsigned WIDTH   = (COUNT == 0) ? 1 : $clog2(COUNT + 1)
) (
   input  logic             SDRAM_CONTROLLER_CLK,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Hold,
`ifdef COUNTDOWN_AUTORELOAD_EN
   input  logic             Auto_Reload,
`endif
   output logic             Done,
   output logic             Busy,
   output logic [WIDTH-1:0] Remaining
);

   localparam int unsigned PW = (PRESCALE <= 1) ? 1 : $clog2(PRESCALE);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      EXPIRED = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [PW-1:0]    prescaler;
   logic [PW-1:0]    prescaler_next;
   logic [WIDTH-1:0] remaining_next;
   logic             done_next;
   logic             auto_reload;
   logic             tick;
   logic             last;

`ifdef COUNTDOWN_AUTORELOAD_EN
   assign auto_reload = Auto_Reload;
`else
   assign auto_reload = 1'b0;
`endif

   assign tick = (prescaler == PW'(PRESCALE - 1));
   assign last = (Remaining == WIDTH'(1));

   // State and datapath registers
   always_ff @(posedge SDRAM_CONTROLLER_CLK) begin
      if (Reset) begin
         state     <= IDLE;
         prescaler <= '0;
         Remaining <= '0;
         Done      <= 1'b0;
         Busy      <= 1'b0;
      end else begin
         state     <= state_next;
         prescaler <= prescaler_next;
         Remaining <= remaining_next;
         Done      <= done_next;
         Busy      <= (state_next == RUN);
      end
   end

   // Next state: Start from anywhere, expiry on the final tick of a run
   always_comb begin
      state_next = state;
      if (Start) begin
         state_next = (COUNT == 0) ? EXPIRED : RUN;
      end else if (state == RUN && !Hold && tick && last) begin
         state_next = auto_reload ? RUN : EXPIRED;
      end
   end

   // Datapath next values; Done in RUN is only ever a one-cycle reload pulse
   always_comb begin
      prescaler_next = prescaler;
      remaining_next = Remaining;
      done_next      = Done;
      if (Start) begin
         prescaler_next = '0;
         remaining_next = WIDTH'(COUNT);
         done_next      = (COUNT == 0);
      end else if (state == RUN) begin
         done_next = 1'b0;
         if (!Hold) begin
            if (tick) begin
               prescaler_next = '0;
               if (last) begin
                  done_next      = 1'b1;
                  remaining_next = auto_reload ? WIDTH'(COUNT) : '0;
               end else if (Remaining != '0) begin
                  remaining_next = Remaining - WIDTH'(1);
               end
            end else begin
               prescaler_next = prescaler + PW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer across several COUNT/PRESCALE settings.
// Auto-reload scenario is compiled only when COUNTDOWN_AUTORELOAD_EN is defined.
module tb_countdown_timer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   tests_run    = 0;
   int   tests_failed = 0;

   logic s1, h1, d1, b1;          logic [0:0]  r1;
   logic s750, h750, d750, b750;  logic [9:0]  r750;
   logic s43, h43, d43, b43;      logic [2:0]  r43;
   logic s10k, h10k, d10k, b10k;  logic [13:0] r10k;
   logic s0, h0, d0, b0;          logic [0:0]  r0;
`ifdef COUNTDOWN_AUTORELOAD_EN
   logic ar_off = 1'b0;
   logic s3, h3, d3, b3, ar3;     logic [1:0]  r3;
`endif

   countdown_timer #(.COUNT(1), .PRESCALE(1)) u1 (
      .SDRAM_CONTROLLER_CLK(clk), .Reset(rst), .Start(s1), .Hold(h1),
`ifdef COUNTDOWN_AUTORELOAD_EN
      .Auto_Reload(ar_off),
`endif
      .Done(d1), .Busy(b1), .Remaining(r1));

   countdown_timer #(.COUNT(750), .PRESCALE(1)) u750 (
      .SDRAM_CONTROLLER_CLK(clk), .Reset(rst), .Start(s750), .Hold(h750),
`ifdef COUNTDOWN_AUTORELOAD_EN
      .Auto_Reload(ar_off),
`endif
      .Done(d750), .Busy(b750), .Remaining(r750));

   countdown_timer #(.COUNT(4), .PRESCALE(3)) u43 (
      .SDRAM_CONTROLLER_CLK(clk), .Reset(rst), .Start(s43), .Hold(h43),
`ifdef COUNTDOWN_AUTORELOAD_EN
      .Auto_Reload(ar_off),
`endif
      .Done(d43), .Busy(b43), .Remaining(r43));

   countdown_timer #(.COUNT(10000), .PRESCALE(1)) u10k (
      .SDRAM_CONTROLLER_CLK(clk), .Reset(rst), .Start(s10k), .Hold(h10k),
`ifdef COUNTDOWN_AUTORELOAD_EN
      .Auto_Reload(ar_off),
`endif
      .Done(d10k), .Busy(b10k), .Remaining(r10k));

   countdown_timer #(.COUNT(0), .PRESCALE(1)) u0 (
      .SDRAM_CONTROLLER_CLK(clk), .Reset(rst), .Start(s0), .Hold(h0),
`ifdef COUNTDOWN_AUTORELOAD_EN
      .Auto_Reload(ar_off),
`endif
      .Done(d0), .Busy(b0), .Remaining(r0));

`ifdef COUNTDOWN_AUTORELOAD_EN
   countdown_timer #(.COUNT(3), .PRESCALE(1)) u3 (
      .SDRAM_CONTROLLER_CLK(clk), .Reset(rst), .Start(s3), .Hold(h3),
      .Auto_Reload(ar3), .Done(d3), .Busy(b3), .Remaining(r3));
`endif

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      s1 = 0; h1 = 0; s750 = 0; h750 = 0; s43 = 0; h43 = 0;
      s10k = 0; h10k = 0; s0 = 0; h0 = 0;
`ifdef COUNTDOWN_AUTORELOAD_EN
      s3 = 0; h3 = 0; ar3 = 0;
`endif
      step(); step();
      tests_run++; if ({d1, b1, r1} !== 3'b000) begin tests_failed++; $display("FAIL reset_u1: got d/b/r=%b/%b/%0d want 0/0/0", d1, b1, r1); end
      tests_run++; if ({d750, b750} !== 2'b00 || r750 !== 10'd0) begin tests_failed++; $display("FAIL reset_u750: got d/b/r=%b/%b/%0d want 0/0/0", d750, b750, r750); end
      tests_run++; if ({d43, b43} !== 2'b00 || r43 !== 3'd0) begin tests_failed++; $display("FAIL reset_u43: got d/b/r=%b/%b/%0d want 0/0/0", d43, b43, r43); end
      tests_run++; if ({d10k, b10k} !== 2'b00 || r10k !== 14'd0) begin tests_failed++; $display("FAIL reset_u10k: got d/b/r=%b/%b/%0d want 0/0/0", d10k, b10k, r10k); end
      tests_run++; if ({d0, b0, r0} !== 3'b000) begin tests_failed++; $display("FAIL reset_u0: got d/b/r=%b/%b/%0d want 0/0/0", d0, b0, r0); end
      rst = 1'b0;
   endtask

   task automatic test_oneshot();
      s1 = 1; step(); s1 = 0;
      tests_run++; if ({d1, b1, r1} !== 3'b011) begin tests_failed++; $display("FAIL oneshot_cycle1: got d/b/r=%b/%b/%0d want 0/1/1", d1, b1, r1); end
      step();
      tests_run++; if ({d1, b1, r1} !== 3'b100) begin tests_failed++; $display("FAIL oneshot_cycle2: got d/b/r=%b/%b/%0d want 1/0/0", d1, b1, r1); end
      h1 = 1; repeat (18) step(); h1 = 0;
      tests_run++; if ({d1, b1} !== 2'b10) begin tests_failed++; $display("FAIL oneshot_sticky20: got d/b=%b/%b want 1/0", d1, b1); end
      s1 = 1; step(); s1 = 0;
      tests_run++; if ({d1, b1, r1} !== 3'b011) begin tests_failed++; $display("FAIL oneshot_restart: got d/b/r=%b/%b/%0d want 0/1/1", d1, b1, r1); end
      step();
      tests_run++; if (d1 !== 1'b1) begin tests_failed++; $display("FAIL oneshot_reexpire: got %b want 1", d1); end
   endtask

   task automatic test_start_at_expiry();
      s1 = 1; step(); step();
      tests_run++; if ({d1, b1, r1} !== 3'b011) begin tests_failed++; $display("FAIL reload_wins: got d/b/r=%b/%b/%0d want 0/1/1", d1, b1, r1); end
      repeat (3) step();
      tests_run++; if ({d1, r1} !== 2'b01) begin tests_failed++; $display("FAIL start_held: got d/r=%b/%0d want 0/1", d1, r1); end
      s1 = 0; step();
      tests_run++; if ({d1, b1} !== 2'b10) begin tests_failed++; $display("FAIL after_release: got d/b=%b/%b want 1/0", d1, b1); end
   endtask

   task automatic test_start_hold();
      int k;
      s750 = 1; repeat (5) step();
      tests_run++; if (r750 !== 10'd750 || d750 !== 1'b0 || b750 !== 1'b1) begin tests_failed++; $display("FAIL hold_start_reload: got d/b/r=%b/%b/%0d want 0/1/750", d750, b750, r750); end
      s750 = 0; step(); k = 1;
      tests_run++; if (r750 !== 10'd749) begin tests_failed++; $display("FAIL rem_after_release: got %0d want 749", r750); end
      while (d750 !== 1'b1 && k < 1000) begin step(); k++; end
      tests_run++; if (k !== 750) begin tests_failed++; $display("FAIL latency750: got %0d edges want 750", k); end
      tests_run++; if (b750 !== 1'b0 || r750 !== 10'd0) begin tests_failed++; $display("FAIL expired750: got b/r=%b/%0d want 0/0", b750, r750); end
   endtask

   task automatic test_prescale();
      int k;
      s43 = 1; step(); s43 = 0;
      step(); step(); k = 2;
      tests_run++; if (r43 !== 3'd4) begin tests_failed++; $display("FAIL presc_rem_k2: got %0d want 4", r43); end
      step(); k = 3;
      tests_run++; if (r43 !== 3'd3) begin tests_failed++; $display("FAIL presc_rem_k3: got %0d want 3", r43); end
      while (d43 !== 1'b1 && k < 100) begin step(); k++; end
      tests_run++; if (k !== 12) begin tests_failed++; $display("FAIL presc_latency: got %0d edges want 12", k); end
      s43 = 1; step(); s43 = 0;
      repeat (4) step();
      h43 = 1; repeat (5) step(); h43 = 0; k = 9;
      tests_run++; if (r43 !== 3'd3 || d43 !== 1'b0) begin tests_failed++; $display("FAIL hold_frozen: got d/r=%b/%0d want 0/3", d43, r43); end
      while (d43 !== 1'b1 && k < 100) begin step(); k++; end
      tests_run++; if (k !== 17) begin tests_failed++; $display("FAIL hold_latency: got %0d edges want 17", k); end
   endtask

   task automatic test_reset_midrun();
      int seen;
      s10k = 1; step(); s10k = 0;
      repeat (5000) step();
      tests_run++; if (r10k !== 14'd5000 || b10k !== 1'b1) begin tests_failed++; $display("FAIL midrun_rem: got b/r=%b/%0d want 1/5000", b10k, r10k); end
      rst = 1; step(); rst = 0;
      tests_run++; if (d10k !== 1'b0 || b10k !== 1'b0 || r10k !== 14'd0) begin tests_failed++; $display("FAIL midrun_reset: got d/b/r=%b/%b/%0d want 0/0/0", d10k, b10k, r10k); end
      seen = 0;
      repeat (6000) begin step(); if (d10k !== 1'b0 || b10k !== 1'b0) seen++; end
      tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL midrun_no_done: got %0d active cycles want 0", seen); end
   endtask

   task automatic test_zero();
      int bad;
      tests_run++; if ({d0, b0} !== 2'b00) begin tests_failed++; $display("FAIL zero_idle: got d/b=%b/%b want 0/0", d0, b0); end
      s0 = 1; step(); s0 = 0;
      tests_run++; if ({d0, b0, r0} !== 3'b100) begin tests_failed++; $display("FAIL zero_immediate: got d/b/r=%b/%b/%0d want 1/0/0", d0, b0, r0); end
      bad = 0; s0 = 1;
      repeat (3) begin step(); if (b0 !== 1'b0) bad++; end
      s0 = 0; step(); if (b0 !== 1'b0) bad++;
      tests_run++; if (bad !== 0 || d0 !== 1'b1) begin tests_failed++; $display("FAIL zero_never_busy: got busy_cycles=%0d d=%b want 0/1", bad, d0); end
   endtask

`ifdef COUNTDOWN_AUTORELOAD_EN
   task automatic test_autoreload();
      logic exp_d;
      ar3 = 1; s3 = 1; step(); s3 = 0;
      for (int k = 1; k <= 9; k++) begin
         step();
         exp_d = (k % 3 == 0);
         tests_run++; if (d3 !== exp_d || b3 !== 1'b1) begin tests_failed++; $display("FAIL autoreload_k%0d: got d/b=%b/%b want %b/1", k, d3, b3, exp_d); end
      end
      tests_run++; if (r3 !== 2'd3) begin tests_failed++; $display("FAIL autoreload_rem: got %0d want 3", r3); end
      ar3 = 0;
      step(); step(); step();
      tests_run++; if ({d3, b3} !== 2'b10 || r3 !== 2'd0) begin tests_failed++; $display("FAIL autoreload_sticky: got d/b/r=%b/%b/%0d want 1/0/0", d3, b3, r3); end
      step(); step();
      tests_run++; if ({d3, b3} !== 2'b10) begin tests_failed++; $display("FAIL autoreload_stays: got d/b=%b/%b want 1/0", d3, b3); end
   endtask
`endif

   initial begin
      test_reset();
      test_oneshot();
      test_start_at_expiry();
      test_start_hold();
      test_prescale();
      test_reset_midrun();
      test_zero();
`ifdef COUNTDOWN_AUTORELOAD_EN
      test_autoreload();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
